// File: rtl/mcpu_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// opcode/funct codes, ALU commands, 4-bit state encodings, mux selects.
package mcpu_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    localparam logic [1:0] DST_RD   = 2'd0;
    localparam logic [1:0] DST_RT   = 2'd1;
    localparam logic [1:0] DST_R31  = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MDR   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;

    localparam logic [1:0] SA_PC    = 2'd0;
    localparam logic [1:0] SA_A     = 2'd1;

    localparam logic [1:0] SB_IMMSH = 2'd0;
    localparam logic [1:0] SB_IMM   = 2'd1;
    localparam logic [1:0] SB_B     = 2'd2;
    localparam logic [1:0] SB_FOUR  = 2'd3;

    localparam logic [1:0] PCS_ALU  = 2'd0;
    localparam logic [1:0] PCS_JMP  = 2'd1;
    localparam logic [1:0] PCS_REG  = 2'd2;
    localparam logic [1:0] PCS_A    = 2'd3;

    // DECODE dispatch; anything unrecognised lands in FAULT.
    function automatic state_t dispatch(input logic [5:0] op,
                                        input logic [5:0] fn);
        state_t s;
        s = S_FAULT;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT)
                    s = S_EXEC_R;
                else if (fn == FN_JR)
                    s = S_JR;
            end
            OP_LW, OP_SW:     s = S_MEM_ADDR;
            OP_ADDI, OP_XORI: s = S_EXEC_I;
            OP_BEQ, OP_BNE:   s = S_BRANCH;
            OP_J:             s = S_JUMP;
            OP_JAL:           s = S_JAL;
            default:          s = S_FAULT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mcpu_mem_wait_timer.sv
// Memory wait counter: counts cycles spent waiting on mem_ready.
// Ports: clk, reset (async low), clear, waiting in; expired out.
module mcpu_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (waiting)
            count <= count + CW'(1);
    end

    // Fires during the MEM_TIMEOUT-th consecutive wait cycle; a cycle
    // with mem_ready high is never a wait cycle, so ready always wins.
    assign expired = (MEM_TIMEOUT != 0) && waiting && (count == LIMIT);

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back,
// all register enables and datapath selects, mem handshake + timeout.
// Ports: clk, reset (async low), opcode, funct, zero, mem_ready in;
// mem_req/we/in, *_we, selects, alu_op, instr_retired, fault,
// state_out out. MCPU_CTRL_PERF_EN adds cycle_count/instr_count.
module mcpu_ctrl_fsm
    import mcpu_ctrl_fsm_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
`ifdef MCPU_CTRL_PERF_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_in,
    output logic               pc_we,
    output logic               ir_we,
    output logic               a_we,
    output logic               b_we,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         reg_in,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               instr_retired,
    output logic               fault,
    output logic [3:0]         state_out
`ifdef MCPU_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count
`endif
);

    state_t state;
    logic   expired;
    logic   waiting;
    logic   clear;

    assign waiting = mem_req & ~mem_ready;
    // Leaving a wait state always happens with ready high, so clearing
    // on "not waiting" is equivalent to clearing on entry.
    assign clear   = ~waiting;

    mcpu_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .waiting(waiting),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
        end else begin
            unique case (state)
                S_RST:    state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)    state <= S_DECODE;
                    else if (expired) state <= S_FAULT;
                end
                S_DECODE:   state <= dispatch(opcode, funct);
                S_EXEC_R:   state <= S_WB_R;
                S_EXEC_I:   state <= S_WB_I;
                S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR
                                                       : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready)    state <= S_WB_MEM;
                    else if (expired) state <= S_FAULT;
                end
                S_MEM_WR: begin
                    if (mem_ready)    state <= S_FETCH;
                    else if (expired) state <= S_FAULT;
                end
                S_WB_R, S_WB_I, S_WB_MEM,
                S_BRANCH, S_JUMP, S_JAL, S_JR:
                    state <= S_FETCH;
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_in        = 1'b0;
        pc_we         = 1'b0;
        ir_we         = 1'b0;
        a_we          = 1'b0;
        b_we          = 1'b0;
        reg_we        = 1'b0;
        reg_dst       = DST_RD;
        reg_in        = WD_ALU;
        alu_src_a     = SA_PC;
        alu_src_b     = SB_IMMSH;
        alu_op        = ALUOP_W'(ALU_ADD);
        pc_src        = PCS_ALU;
        instr_retired = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_src_b = SB_FOUR;
                end
            end
            S_DECODE: begin
                a_we = 1'b1;
                b_we = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SA_A;
                alu_src_b = SB_B;
                if (funct == FN_SUB)
                    alu_op = ALUOP_W'(ALU_SUB);
                else if (funct == FN_SLT)
                    alu_op = ALUOP_W'(ALU_SLT);
            end
            S_WB_R: begin
                reg_we        = 1'b1;
                instr_retired = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = SA_A;
                alu_src_b = SB_IMM;
                if (opcode == OP_XORI)
                    alu_op = ALUOP_W'(ALU_XOR);
            end
            S_WB_I: begin
                reg_we        = 1'b1;
                reg_dst       = DST_RT;
                instr_retired = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = SA_A;
                alu_src_b = SB_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                mem_in  = 1'b1;
            end
            S_WB_MEM: begin
                reg_we        = 1'b1;
                reg_dst       = DST_RT;
                reg_in        = WD_MDR;
                instr_retired = 1'b1;
            end
            S_MEM_WR: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                mem_in        = 1'b1;
                instr_retired = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a     = SA_A;
                alu_src_b     = SB_B;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_src        = PCS_REG;
                pc_we         = (opcode == OP_BNE) ? ~zero : zero;
                instr_retired = 1'b1;
            end
            S_JUMP: begin
                pc_we         = 1'b1;
                pc_src        = PCS_JMP;
                instr_retired = 1'b1;
            end
            S_JAL: begin
                pc_we         = 1'b1;
                pc_src        = PCS_JMP;
                reg_we        = 1'b1;
                reg_dst       = DST_R31;
                reg_in        = WD_PC;
                instr_retired = 1'b1;
            end
            S_JR: begin
                pc_we         = 1'b1;
                pc_src        = PCS_A;
                instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault     = (state == S_FAULT);
    assign state_out = state;

`ifdef MCPU_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state != S_RST && state != S_FAULT)
                cycle_count <= cycle_count + CNT_W'(1);
            if (instr_retired)
                instr_count <= instr_count + CNT_W'(1);
        end
    end
`endif

endmodule
